// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC sequencing (boot, increment, redirect, stall, irq, halt); optional PC_SEQUENCER_WRAP_TRAP_EN halts on increment past 16'hFFFF
module pc_sequencer #(
  parameter logic [15:0] RESET_VEC   = 16'h0000,
  parameter logic [15:0] IRQ_VEC     = 16'h0004,
  parameter int          BOOT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pcout,
  input  logic        hazard_stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic        jump,
  input  logic [15:0] jump_target,
  input  logic        irq,
  input  logic        iret,
  input  logic        halt_instr,
  output logic [15:0] pcnext,
  output logic        Fstall,
  output logic        Dflush,
  output logic        irq_ack,
  output logic [15:0] epc,
  output logic        in_isr,
  output logic        halted
);
  localparam logic [1:0] BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2;
  logic [1:0]  state;
  logic [15:0] cnt;
  logic        run, take_iret, take_irq, redirect, trap;
  // Next-PC arbitration; flush of any redirect overrides a hazard stall
  always_comb begin
    run       = !reset && state == RUN;
    take_iret = iret && in_isr;
    take_irq  = irq && !in_isr;
    redirect  = take_iret || take_irq || branch_taken || jump;
`ifdef PC_SEQUENCER_WRAP_TRAP_EN
    trap      = run && !halt_instr && !redirect && !hazard_stall && pcout == 16'hFFFF;
`else
    trap      = 1'b0;
`endif
    pcnext    = (reset || state == BOOT) ? RESET_VEC :
                (state != RUN || halt_instr) ? pcout :
                take_iret ? epc :
                take_irq ? IRQ_VEC :
                branch_taken ? branch_target :
                jump ? jump_target :
                (hazard_stall || trap) ? pcout : pcout + 16'd1;
    Fstall    = !reset && (state == HALT || (run && (halt_instr || (!redirect && hazard_stall))));
    Dflush    = reset || state != RUN || halt_instr || redirect;
    irq_ack   = run && !halt_instr && take_irq;
    halted    = !reset && state == HALT;
  end
  // Boot countdown, halt entry and interrupt bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= BOOT;
      cnt    <= 16'(BOOT_CYCLES - 1);
      epc    <= 16'h0000;
      in_isr <= 1'b0;
    end else if (state == BOOT) begin
      cnt <= cnt - 16'd1;
      if (cnt == 16'd0) state <= RUN;
    end else if (run) begin
      if (halt_instr || trap) state <= HALT;
      else if (take_iret) in_isr <= 1'b0;
      else if (take_irq) begin
        in_isr <= 1'b1;
        epc    <= branch_taken ? branch_target : jump ? jump_target : pcout;
      end
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: randomized and directed self-checking bench for pc_sequencer
module tb_pc_sequencer;
  logic        clk = 1'b0, reset = 1'b1;
  logic [15:0] pcout = '0, branch_target = '0, jump_target = '0;
  logic        hazard_stall = 0, branch_taken = 0, jump = 0, irq = 0, iret = 0, halt_instr = 0;
  logic [15:0] pcnext, epc;
  logic        Fstall, Dflush, irq_ack, in_isr, halted;
  int checks = 0, failures = 0;
  bit started = 0;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .pcout(pcout), .hazard_stall(hazard_stall),
    .branch_taken(branch_taken), .branch_target(branch_target), .jump(jump),
    .jump_target(jump_target), .irq(irq), .iret(iret), .halt_instr(halt_instr),
    .pcnext(pcnext), .Fstall(Fstall), .Dflush(Dflush), .irq_ack(irq_ack),
    .epc(epc), .in_isr(in_isr), .halted(halted)
  );

  always #5 clk = ~clk;

`ifdef PC_SEQUENCER_WRAP_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: mode 0=boot 1=run 2=halt, boot_left counts remaining boot cycles
  int          mode = 0, boot_left = 4;
  logic [15:0] m_epc = '0;
  logic        m_isr = 0;

  always @(posedge clk) begin
    started <= 1;
    if (reset) begin
      mode <= 0; boot_left <= 4; m_epc <= '0; m_isr <= 0;
    end else if (mode == 0) begin
      boot_left <= boot_left - 1;
      if (boot_left == 1) mode <= 1;
    end else if (mode == 1) begin
      if (halt_instr) mode <= 2;
      else if (iret && m_isr) m_isr <= 0;
      else if (irq && !m_isr) begin
        m_isr <= 1;
        m_epc <= branch_taken ? branch_target : jump ? jump_target : pcout;
      end else if (TRAP && !branch_taken && !jump && !hazard_stall && pcout == 16'hFFFF) mode <= 2;
    end
  end

  always @(negedge clk) begin : cmp
    logic [15:0] pn;
    logic fs, df, ack, hl;
    if (started) begin
      pn = pcout; fs = 0; df = 0; ack = 0; hl = 0;
      if (reset || mode == 0) begin pn = 16'h0000; df = 1; end
      else if (mode == 2) begin fs = 1; df = 1; hl = 1; end
      else if (halt_instr) begin fs = 1; df = 1; end
      else if (iret && m_isr) begin pn = m_epc; df = 1; end
      else if (irq && !m_isr) begin pn = 16'h0004; df = 1; ack = 1; end
      else if (branch_taken) begin pn = branch_target; df = 1; end
      else if (jump) begin pn = jump_target; df = 1; end
      else if (hazard_stall) fs = 1;
      else if (!(TRAP && pcout == 16'hFFFF)) pn = pcout + 16'd1;
      chk("pcnext", pcnext, pn);
      chk("Fstall", 16'(Fstall), 16'(fs));
      chk("Dflush", 16'(Dflush), 16'(df));
      chk("irq_ack", 16'(irq_ack), 16'(ack));
      chk("halted", 16'(halted), 16'(hl));
      chk("epc", epc, m_epc);
      chk("in_isr", 16'(in_isr), 16'(m_isr));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    reset = 0; hazard_stall = 0; branch_taken = 0; jump = 0; irq = 0; iret = 0; halt_instr = 0;
  endtask

  task automatic rnd(input int halt_div, input int rst_div);
    reset         = $urandom_range(0, rst_div) == 0;
    halt_instr    = $urandom_range(0, halt_div) == 0;
    irq           = $urandom_range(0, 4) == 0;
    iret          = $urandom_range(0, 5) == 0;
    branch_taken  = $urandom_range(0, 3) == 0;
    jump          = $urandom_range(0, 3) == 0;
    hazard_stall  = $urandom_range(0, 2) == 0;
    branch_target = 16'($urandom);
    jump_target   = 16'($urandom);
    pcout         = $urandom_range(0, 15) == 0 ? 16'hFFFF : 16'($urandom);
  endtask

  initial begin
    cyc(); reset = 1; rnd(3, 1000); reset = 1; #1;
    chk("rst_pcnext", pcnext, 16'h0000);
    chk("rst_dflush", 16'(Dflush), 16'd1);
    for (int i = 0; i < 4; i++) begin
      cyc(); rnd(3, 1000); reset = 0; #1;
      chk("boot_pcnext", pcnext, 16'h0000);
      chk("boot_dflush", 16'(Dflush), 16'd1);
    end
    cyc(); pcout = 16'h0000; #1; chk("run_inc0", pcnext, 16'h0001);
    cyc(); pcout = 16'h0001; #1; chk("run_inc1", pcnext, 16'h0002);
    for (int i = 0; i < 2; i++) begin
      cyc(); pcout = 16'h0010; hazard_stall = 1; #1;
      chk("stall_fstall", 16'(Fstall), 16'd1);
      chk("stall_pc", pcnext, 16'h0010);
    end
    cyc(); pcout = 16'h0010; #1; chk("stall_release", pcnext, 16'h0011);
    cyc(); pcout = 16'h0020; branch_taken = 1; branch_target = 16'h0100; hazard_stall = 1; #1;
    chk("br_pc", pcnext, 16'h0100);
    chk("br_fstall", 16'(Fstall), 16'd0);
    chk("br_dflush", 16'(Dflush), 16'd1);
    cyc(); pcout = 16'h0030; irq = 1; #1;
    chk("irq_pc", pcnext, 16'h0004);
    chk("irq_ack", 16'(irq_ack), 16'd1);
    cyc(); pcout = 16'h0004; irq = 1; #1;
    chk("irq_epc", epc, 16'h0030);
    chk("irq_isr", 16'(in_isr), 16'd1);
    chk("irq_nested_ack", 16'(irq_ack), 16'd0);
    chk("irq_nested_pc", pcnext, 16'h0005);
    cyc(); pcout = 16'h0005; iret = 1; irq = 1; #1;
    chk("iret_pc", pcnext, 16'h0030);
    cyc(); pcout = 16'h0040; #1;
    chk("iret_isr", 16'(in_isr), 16'd0);
    cyc(); pcout = 16'h0050; irq = 1; branch_taken = 1; branch_target = 16'h0200; #1;
    chk("irqbr_pc", pcnext, 16'h0004);
    cyc(); pcout = 16'h0004; iret = 1; #1;
    chk("irqbr_epc", epc, 16'h0200);
    chk("irqbr_iret", pcnext, 16'h0200);
    cyc(); pcout = 16'hFFFF; #1;
`ifndef PC_SEQUENCER_WRAP_TRAP_EN
    chk("wrap_pc", pcnext, 16'h0000);
    cyc(); pcout = 16'h0000; #1;
    chk("wrap_halted", 16'(halted), 16'd0);
    cyc(); halt_instr = 1; #1;
`else
    cyc(); pcout = 16'hFFFF; #1;
`endif
    chk("halt_fstall", 16'(Fstall), 16'd1);
    for (int i = 0; i < 10; i++) begin
      cyc(); rnd(0, 1000); reset = 0; #1;
      chk("halt_halted", 16'(halted), 16'd1);
      chk("halt_hold", 16'(Fstall), 16'd1);
    end
    cyc(); reset = 1; #1;
    chk("rehalt_rst", 16'(halted), 16'd0);
    cyc(); #1;
    chk("reboot_pc", pcnext, 16'h0000);
    chk("reboot_flush", 16'(Dflush), 16'd1);
    for (int i = 0; i < 800; i++) begin
      cyc(); rnd(80, 60);
    end
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Controller that sequences the 16-bit fetch PC register. Drives its `pcnext` and `Fstall` inputs every cycle.
- Arbitrates between boot, sequential increment, branch/jump redirect, hazard stall, interrupt entry/return and halt.
- Generates the decode-stage flush.
- Sits between the PC register, the hazard unit and the execute-stage branch resolution logic.

Parameters:
- RESET_VEC, 16'h0000, address loaded into the PC during boot.
- IRQ_VEC, 16'h0004, interrupt service routine entry address.
- BOOT_CYCLES, 4, number of cycles (≥1) the boot vector is forced before normal fetch.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pcout  in  16  current PC value from the PC register.
- hazard_stall  in  1  load-use/structural stall request from the hazard unit.
- branch_taken  in  1  execute-stage branch resolved taken.
- branch_target  in  16  branch destination.
- jump  in  1  unconditional jump in execute.
- jump_target  in  16  jump destination.
- irq  in  1  level-sensitive interrupt request.
- iret  in  1  return-from-interrupt instruction in execute.
- halt_instr  in  1  halt instruction in execute.
- pcnext  out  16  next PC to the PC register.
- Fstall  out  1  hold PC register.
- Dflush  out  1  squash the fetch/decode pipeline register.
- irq_ack  out  1  one-cycle pulse when an interrupt is taken.
- epc  out  16  saved return address.
- in_isr  out  1  interrupt service in progress.
- halted  out  1  core halted.

Behaviour:
- Timing:
  - State, counter, `epc` and `in_isr` are registered.
  - `pcnext`, `Fstall`, `Dflush` and `irq_ack` are combinational from registered state plus current inputs.
  - The PC updates on the edge following the decision (1-cycle latency).
- FSM states: BOOT, RUN, HALT.
- Reset (sync):
  - state=BOOT, boot counter=BOOT_CYCLES-1.
  - `epc`=16'h0000, `in_isr`=0.
  - While `reset` is high: `pcnext`=RESET_VEC, `Fstall`=0, `Dflush`=1, `irq_ack`=0, `halted`=0.
- BOOT:
  - `pcnext`=RESET_VEC, `Fstall`=0, `Dflush`=1.
  - All other inputs are ignored.
  - Counter decrements each cycle; when it reaches 0, go to RUN.
  - The PC register has no reset of its own; this state initialises it.
- RUN priority (highest first), evaluated each cycle:
  1. `halt_instr`: go to HALT; `Fstall`=1, `Dflush`=1.
  2. `iret` with `in_isr`=1: `pcnext`=`epc`, `Dflush`=1, `in_isr`<=0. If `in_isr`=0, `iret` is treated as a NOP.
  3. `irq` with `in_isr`=0:
     - `pcnext`=IRQ_VEC, `Dflush`=1, `irq_ack`=1, `in_isr`<=1.
     - `epc`<= `branch_target` if `branch_taken`, else `jump_target` if `jump`, else `pcout`.
  4. `branch_taken`: `pcnext`=`branch_target`, `Dflush`=1 (`branch_taken` beats `jump`).
  5. `jump`: `pcnext`=`jump_target`, `Dflush`=1.
  6. `hazard_stall`: `Fstall`=1, `pcnext`=`pcout`, `Dflush`=0.
  7. Default: `pcnext`=`pcout`+1 (16-bit), `Fstall`=0, `Dflush`=0.
- Redirects (rows 2–5) force `Fstall`=0 even when `hazard_stall`=1; flush overrides stall.
- Interrupt rules:
  - `irq` while `in_isr`=1 stays pending; no nesting.
  - `irq` and `iret` in the same cycle: `iret` wins. `irq` is taken the next cycle if still asserted, with `epc`=`pcout`.
- HALT:
  - `Fstall`=1, `pcnext`=`pcout`, `Dflush`=1, `halted`=1.
  - All inputs are ignored; only `reset` exits.
- Reset asserted mid-operation (any state, including mid-BOOT or in ISR) restarts the full BOOT sequence and clears `in_isr` and `epc`.

Optional Feature:
- PC_SEQUENCER_WRAP_TRAP_EN:
  - When defined, a default sequential increment with `pcout`=16'hFFFF does not wrap. The FSM enters HALT instead: `Fstall`=1, `halted`=1 from the next cycle.
  - When undefined, the increment wraps modulo 2^16 to 16'h0000 with no side effect.
  - Redirects to any address are unaffected in both cases.

Test Plan:
- Reset 1 cycle, BOOT_CYCLES=4 → `pcnext`=0000 with `Dflush`=1 for 4 cycles; then `pcnext`=`pcout`+1 (0000→0001→0002).
- In RUN, `pcout`=0010, `hazard_stall`=1 for 2 cycles → `Fstall`=1 and PC holds 0010; on release, `pcnext`=0011.
- `pcout`=0020, `branch_taken`=1, `branch_target`=0100, `hazard_stall`=1 → `pcnext`=0100, `Fstall`=0, `Dflush`=1.
- `pcout`=0030, `irq`=1 → `pcnext`=0004, `irq_ack` pulse, `epc`=0030, `in_isr`=1. A second `irq` is ignored. Then `iret` → `pcnext`=0030, `in_isr`=0.
- `irq`=1 with `branch_taken`, `branch_target`=0200 → `epc`=0200, `pcnext`=0004.
- `halt_instr`=1 → `halted`=1, `Fstall`=1 held for 10 cycles under random inputs. Then reset → BOOT.
- `pcout`=FFFF, no redirect → without the macro, `pcnext`=0000; with PC_SEQUENCER_WRAP_TRAP_EN, `halted`=1 next cycle.
